// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the NCO clock-enable generator.
// Latency: n/a (types and elaboration-time constants only).
// Backpressure: n/a.
package clk_gen_pkg;

    // Lock FSM: RESET_WAIT and SETTLE both count settle cycles.
    // They are kept as distinct states so a probe can tell a reset recovery
    // apart from a reconfiguration recovery.
    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        RUN        = 2'd1,
        SETTLE     = 2'd2
    } state_t;

    // Phase increment for a target rate: round(out_hz * 2^acc_w / ref_hz).
    // The real-to-integer cast rounds to the nearest integer.
    function automatic logic [63:0] calc_inc(input real ref_hz, input real out_hz, input int acc_w);
        real scaled;
        scaled = out_hz * (2.0 ** acc_w) / ref_hz;
        return 64'(longint'(scaled));
    endfunction

    // Board reference and the NES rates this block is normally configured for.
    localparam real BOARD_REF_HZ = 50.0e6;
    localparam real NES_CPU_HZ   = 1.789773e6;
    localparam real NES_PPU_HZ   = 5.369318e6;

endpackage

// File: rtl/nco_acc_ch.sv
// One NCO channel: phase accumulator, increment register, carry strobe, square output.
// Latency: the strobe and square outputs are registered, one cycle after the carrying edge.
// Backpressure: none. A load overrides the accumulate step, and reset overrides the load.
module nco_acc_ch #(
    parameter int ACC_W = 32
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [ACC_W-1:0] rst_inc,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] load_phase,
    output logic             strobe,
    output logic             square
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;

    // The carry out of the wrapping add marks one output period.
    assign sum = {1'b0, acc} + {1'b0, inc};

    // Accumulator update: a load replaces the step on this edge, and disable freezes the phase.
    always_ff @(posedge refclk) begin
        if (rst) begin
            acc    <= '0;
            inc    <= rst_inc;
            strobe <= 1'b0;
            square <= 1'b0;
        end else if (load) begin
            acc    <= load_phase;
            inc    <= load_inc;
            strobe <= 1'b0;
            square <= load_phase[ACC_W-1];
        end else if (enable) begin
            acc    <= sum[ACC_W-1:0];
            strobe <= sum[ACC_W];
            square <= sum[ACC_W-1];
        end else begin
            strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/nco_clk_en_gen.sv
// Multi-channel NCO clock-enable generator with a lock indication and a reconfiguration port.
// Latency: strobes lag the carrying edge by 1 cycle; locked rises LOCK_CYCLES cycles after reset or reconfig.
// Backpressure: cfg_ready is low while settling, and one request is accepted per settle window.
module nco_clk_en_gen
    import clk_gen_pkg::*;
#(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = 32,
    parameter int                      LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_INC = {NUM_CH{ACC_W'(calc_inc(4.0, 1.0, ACC_W))}},
    localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] outclk_en,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  settle_cnt;
    logic              cfg_fire;
    logic              ch_ok;
    logic [NUM_CH-1:0] load;

    // cfg_ready is high only in RUN, so a handshake can only fire from RUN.
    assign cfg_fire = cfg_valid && cfg_ready;
    assign ch_ok    = (32'(cfg_ch) < 32'(NUM_CH));

    // Decode the target channel. An out-of-range channel loads nothing.
    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = cfg_fire && (32'(cfg_ch) == 32'(i));
        end
    end

    // Lock FSM: count settle cycles, then open the config port. An accepted reconfig restarts the count.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state      <= RESET_WAIT;
            settle_cnt <= '0;
            locked     <= 1'b0;
            cfg_ready  <= 1'b0;
        end else begin
            case (state)
                RESET_WAIT, SETTLE: begin
                    if (settle_cnt == CNT_LAST) begin
                        state      <= RUN;
                        settle_cnt <= '0;
                        locked     <= 1'b1;
                        cfg_ready  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // Out-of-range requests are consumed without disturbing the lock.
                    if (cfg_fire && ch_ok) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        locked     <= 1'b0;
                        cfg_ready  <= 1'b0;
                    end
                end
                default: begin
                    state      <= RESET_WAIT;
                    settle_cnt <= '0;
                    locked     <= 1'b0;
                    cfg_ready  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nco_acc_ch #(
            .ACC_W (ACC_W)
        ) u_ch (
            .refclk     (refclk),
            .rst        (rst),
            .enable     (enable),
            .load       (load[i]),
            .rst_inc    (DEFAULT_INC[i*ACC_W +: ACC_W]),
            .load_inc   (cfg_inc),
            .load_phase (cfg_phase),
            .strobe     (outclk_en[i]),
            .square     (outclk[i])
        );
    end

endmodule

// File: tb/tb_nco_clk_en_gen.sv
// Self-checking bench for nco_clk_en_gen: a cycle reference model plus directed scenarios and random traffic.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: the bench acts as the config master and drives cfg_valid freely.
module tb_nco_clk_en_gen;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int LC  = 16;
    localparam logic [31:0] DEF_INC = 32'h4000_0000;

    logic           refclk = 1'b0;
    logic           rst;
    logic           enable;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [AW-1:0]  cfg_inc;
    logic [AW-1:0]  cfg_phase;
    logic [NCH-1:0] outclk_en;
    logic [NCH-1:0] outclk;
    logic           locked;

    nco_clk_en_gen #(
        .NUM_CH      (NCH),
        .ACC_W       (AW),
        .LOCK_CYCLES (LC)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .outclk_en (outclk_en),
        .outclk    (outclk),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    // Reference model. Each channel keeps its total phase as an unbounded count.
    // A strobe is a change in the whole-cycle part of that count, and the square
    // output is the half-cycle bit. Lock is counted as cycles since the last event.
    longint unsigned ph [NCH];
    logic [31:0]     m_inc [NCH];
    logic [NCH-1:0]  m_en;
    logic [NCH-1:0]  m_clk;
    logic            m_locked;
    int              since;

    int checks = 0;
    int errors = 0;
    int stepno = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, stepno);
        end
    endtask

    task automatic model_edge();
        logic hs;
        longint unsigned old;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                ph[i] = 0;
                m_inc[i] = DEF_INC;
            end
            m_en = '0;
            m_clk = '0;
            m_locked = 1'b0;
            since = 0;
        end else begin
            hs = cfg_valid && m_locked;
            for (int i = 0; i < NCH; i++) begin
                if (hs && int'(cfg_ch) == i) begin
                    ph[i] = longint'(cfg_phase);
                    m_inc[i] = cfg_inc;
                    m_en[i] = 1'b0;
                    m_clk[i] = cfg_phase[31];
                end else if (enable) begin
                    old = ph[i];
                    ph[i] = old + longint'(m_inc[i]);
                    m_en[i] = ((ph[i] >> 32) != (old >> 32));
                    m_clk[i] = ph[i][31];
                end else begin
                    m_en[i] = 1'b0;
                end
            end
            if (hs && int'(cfg_ch) < NCH) begin
                m_locked = 1'b0;
                since = 0;
            end else if (!m_locked) begin
                since++;
                if (since >= LC) m_locked = 1'b1;
            end
        end
    endtask

    // One clock: advance the model with the inputs the DUT sees, then compare every output.
    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        stepno++;
        chk("outclk_en", 64'(outclk_en), 64'(m_en));
        chk("outclk", 64'(outclk), 64'(m_clk));
        chk("locked", 64'(locked), 64'(m_locked));
        chk("cfg_ready", 64'(cfg_ready), 64'(m_locked));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int cnt;
        int last0;
        int n;
        bit seen;

        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        cfg_ch = 2'd0; cfg_inc = '0; cfg_phase = '0;
        step(); step();
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_ready", 64'(cfg_ready), 64'd0);
        chk("rst_outclk", 64'(outclk), 64'd0);

        // Lock latency from reset release, with the channels running.
        rst = 1'b0; enable = 1'b1;
        first = -1;
        for (int k = 1; k <= 40 && first < 0; k++) begin
            step();
            if (locked) first = k;
        end
        chk("lock_latency", 64'(first), 64'd16);

        // Default increment: ch0 strobes every 4th cycle; the square output is 2 high, 2 low.
        last0 = -1; cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (outclk[0]) cnt++;
            if (outclk_en[0]) begin
                if (last0 >= 0) chk("ch0_period", 64'(stepno - last0), 64'd4);
                last0 = stepno;
            end
        end
        chk("ch0_duty", 64'(cnt), 64'd8);

        // ch1 at one third of the rate: 999 strobes in 3000 cycles.
        cfg_ch = 2'd1; cfg_inc = 32'h5555_5555; cfg_phase = '0; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("hs_ready_drop", 64'(cfg_ready), 64'd0);
        cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (outclk_en[1]) cnt++;
        end
        chk("ch1_strobes_3000", 64'(cnt), 64'd999);

        // Half-rate reload with a preloaded phase: settle window and immediate strobe.
        cfg_ch = 2'd1; cfg_inc = 32'h8000_0000; cfg_phase = 32'h8000_0000; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("settle_lock_T", 64'(locked), 64'd0);
        last0 = -1;
        for (int k = 1; k <= LC; k++) begin
            step();
            if (k == 1) chk("ch1_strobe_T1", 64'(outclk_en[1]), 64'd1);
            chk(k < LC ? "settle_low" : "settle_relock", 64'(locked), (k < LC) ? 64'd0 : 64'd1);
            if (outclk_en[0]) begin
                if (last0 >= 0) chk("ch0_cadence_reconfig", 64'(stepno - last0), 64'd4);
                last0 = stepno;
            end
        end

        // Out-of-range channel: consumed, with no change to the lock.
        cfg_ch = 2'd3; cfg_inc = 32'h1234_5678; cfg_phase = 32'hFFFF_0000; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("bad_ch_locked", 64'(locked), 64'd1);
        chk("bad_ch_ready", 64'(cfg_ready), 64'd1);
        step();

        // Pause for 10 cycles right after a ch0 strobe + 2 cycles; the cadence resumes from the same phase.
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = outclk_en[0];
        end
        chk("pause_sync", 64'(seen), 64'd1);
        step(); step();
        enable = 1'b0; cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (outclk_en != '0) cnt++;
        end
        chk("pause_no_strobes", 64'(cnt), 64'd0);
        enable = 1'b1; n = 0; seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            step();
            if (outclk_en[0]) begin
                seen = 1'b1;
                n = k;
            end
        end
        chk("resume_gap", 64'(2 + n), 64'd4);

        // Reset during SETTLE together with cfg_valid: increments revert to the defaults.
        cfg_ch = 2'd0; cfg_inc = 32'h0100_0000; cfg_phase = 32'h7000_0000; cfg_valid = 1'b1;
        step();
        chk("pre_rst_settle", 64'(locked), 64'd0);
        step(); step();
        rst = 1'b1; cfg_ch = 2'd1;
        step();
        chk("mid_rst_en", 64'(outclk_en), 64'd0);
        chk("mid_rst_clk", 64'(outclk), 64'd0);
        chk("mid_rst_lock", 64'(locked), 64'd0);
        rst = 1'b0; cfg_valid = 1'b0;
        first = -1;
        for (int k = 1; k <= 8 && first < 0; k++) begin
            step();
            if (outclk_en[1]) first = k;
        end
        chk("ch1_default_restored", 64'(first), 64'd4);
        for (int k = 0; k < LC; k++) step();

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 499) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            cfg_valid = ($urandom_range(0, 15) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_inc   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            cfg_phase = 32'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
